// File: rtl/guard_pkg.sv
// Shared types and constants for the guard reset sequencer.
package guard_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISOLATE,
        ST_RESET,
        ST_WAIT_CLEAR
    } guard_rst_state_e;

    localparam int CauseWr = 0;
    localparam int CauseRd = 1;

endpackage

// File: rtl/guard_reset_ctrl.sv
// Recovery sequencer: isolates the slave, holds it in reset for a programmed
// time, and waits for a software acknowledge before re-enabling the guards.
module guard_reset_ctrl
    import guard_pkg::*;
#(
    parameter int CntWidth      = 8,
    parameter int IsolateCycles = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                enable_i,
    input  logic                wr_reset_req_i,
    input  logic                rd_reset_req_i,
    input  logic                reset_clear_i,
    input  logic [CntWidth-1:0] rst_hold_i,
    output logic                guard_ena_o,
    output logic                isolate_o,
    output logic                slv_rst_no,
    output logic                irq_o,
    output logic [1:0]          cause_o,
    output logic                busy_o,
    output logic [CntWidth-1:0] rst_count_o
);

    localparam logic [CntWidth-1:0] IsoLoad = CntWidth'(IsolateCycles - 1);

    guard_rst_state_e    state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [CntWidth-1:0] count_q, count_d;
    logic [CntWidth-1:0] hold_load;
    logic [1:0]          cause_q, cause_d;
    logic [1:0]          req;

    always_comb begin
        req          = '0;
        req[CauseWr] = wr_reset_req_i;
        req[CauseRd] = rd_reset_req_i;
    end

    // A zero hold length is treated as a single cycle of slave reset.
    assign hold_load = (rst_hold_i == '0) ? '0 : rst_hold_i - CntWidth'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (enable_i && (|req)) begin
                    state_d = ST_ISOLATE;
                    cnt_d   = IsoLoad;
                    cause_d = req;
                end
            end
            ST_ISOLATE: begin
                cause_d = cause_q | req;
                if (cnt_q == '0) begin
                    state_d = ST_RESET;
                    cnt_d   = hold_load;
                end else begin
                    cnt_d = cnt_q - CntWidth'(1);
                end
            end
            ST_RESET: begin
                cause_d = cause_q | req;
                if (cnt_q == '0) begin
                    state_d = ST_WAIT_CLEAR;
                    count_d = (&count_q) ? count_q : count_q + CntWidth'(1);
                end else begin
                    cnt_d = cnt_q - CntWidth'(1);
                end
            end
            ST_WAIT_CLEAR: begin
                if (reset_clear_i) begin
                    state_d = ST_IDLE;
                    cause_d = '0;
                end else begin
                    cause_d = cause_q | req;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cause_q     <= '0;
            count_q     <= '0;
            guard_ena_o <= 1'b0;
            isolate_o   <= 1'b0;
            slv_rst_no  <= 1'b1;
            irq_o       <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cause_q     <= cause_d;
            count_q     <= count_d;
            guard_ena_o <= enable_i && (state_d == ST_IDLE);
            isolate_o   <= (state_d != ST_IDLE);
            slv_rst_no  <= (state_d != ST_RESET);
            irq_o       <= (state_d != ST_IDLE);
            busy_o      <= (state_d != ST_IDLE);
        end
    end

    assign cause_o     = cause_q;
    assign rst_count_o = count_q;

endmodule

// File: tb/tb_guard_reset_ctrl.sv
// Bench for guard_reset_ctrl: directed scenarios plus random traffic checked
// against a timestamp-based model of each recovery sequence.
module tb_guard_reset_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable, wr_req, rd_req, clear;
    logic [7:0] hold8;
    logic [1:0] hold2;

    logic       ge0, iso0, slv0, irq0, busy0;
    logic [1:0] cause0;
    logic [7:0] cnt0;
    logic       ge1, iso1, slv1, irq1, busy1;
    logic [1:0] cause1;
    logic [1:0] cnt1;

    assign hold2 = hold8[1:0];

    always #5 clk = ~clk;

    guard_reset_ctrl #(.CntWidth(8), .IsolateCycles(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable),
        .wr_reset_req_i(wr_req), .rd_reset_req_i(rd_req),
        .reset_clear_i(clear), .rst_hold_i(hold8),
        .guard_ena_o(ge0), .isolate_o(iso0), .slv_rst_no(slv0), .irq_o(irq0),
        .cause_o(cause0), .busy_o(busy0), .rst_count_o(cnt0)
    );

    guard_reset_ctrl #(.CntWidth(2), .IsolateCycles(3)) dut_sat (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable),
        .wr_reset_req_i(wr_req), .rd_reset_req_i(rd_req),
        .reset_clear_i(clear), .rst_hold_i(hold2),
        .guard_ena_o(ge1), .isolate_o(iso1), .slv_rst_no(slv1), .irq_o(irq1),
        .cause_o(cause1), .busy_o(busy1), .rst_count_o(cnt1)
    );

    int checks = 0;
    int errors = 0;
    int k = 0;

    // Model: each sequence is described by its trigger edge t0 and hold h.
    int m_ic [2] = '{4, 3};
    int m_max[2] = '{255, 3};
    bit m_seq[2];
    int m_t0 [2];
    int m_h  [2];
    int m_cause[2];
    int m_cnt[2];
    bit e_ge[2], e_slv[2];

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", tag, k, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_seq[i] = 0; m_t0[i] = 0; m_h[i] = 0; m_cause[i] = 0; m_cnt[i] = 0;
            e_ge[i] = 0; e_slv[i] = 1;
        end
    endtask

    task automatic model_edge(input int i, input bit en, input bit wr, input bit rd,
                              input bit clr, input int hold_in);
        int req;
        int rs, re;
        req = (rd ? 2 : 0) + (wr ? 1 : 0);
        if (!m_seq[i]) begin
            if (en && req != 0) begin
                m_seq[i] = 1; m_t0[i] = k; m_h[i] = 0; m_cause[i] = req;
            end
        end else begin
            if (k == m_t0[i] + m_ic[i]) m_h[i] = (hold_in == 0) ? 1 : hold_in;
            if (m_h[i] != 0 && k == m_t0[i] + m_ic[i] + m_h[i])
                m_cnt[i] = (m_cnt[i] < m_max[i]) ? m_cnt[i] + 1 : m_max[i];
            if (m_h[i] != 0 && k > m_t0[i] + m_ic[i] + m_h[i] && clr) begin
                m_seq[i] = 0; m_cause[i] = 0;
            end else begin
                m_cause[i] = m_cause[i] | req;
            end
        end
        rs = m_t0[i] + m_ic[i];
        re = rs + m_h[i];
        e_ge[i]  = !m_seq[i] && en;
        e_slv[i] = !(m_seq[i] && m_h[i] != 0 && k >= rs && k < re);
    endtask

    task automatic check_inst(input int i, input logic ge, input logic iso, input logic slv,
                              input logic irq, input logic busy, input logic [1:0] cause,
                              input int cnt);
        chk($sformatf("u%0d_guard_ena", i), int'(ge), int'(e_ge[i]));
        chk($sformatf("u%0d_isolate", i), int'(iso), int'(m_seq[i]));
        chk($sformatf("u%0d_slv_rst_n", i), int'(slv), int'(e_slv[i]));
        chk($sformatf("u%0d_irq", i), int'(irq), int'(m_seq[i]));
        chk($sformatf("u%0d_busy", i), int'(busy), int'(m_seq[i]));
        chk($sformatf("u%0d_cause", i), int'(cause), m_cause[i]);
        chk($sformatf("u%0d_rst_count", i), cnt, m_cnt[i]);
    endtask

    task automatic check_all();
        check_inst(0, ge0, iso0, slv0, irq0, busy0, cause0, int'(cnt0));
        check_inst(1, ge1, iso1, slv1, irq1, busy1, cause1, int'(cnt1));
    endtask

    task automatic step(input bit en, input bit wr, input bit rd, input bit clr,
                        input int hold);
        enable = en; wr_req = wr; rd_req = rd; clear = clr; hold8 = 8'(hold);
        k++;
        model_edge(0, en, wr, rd, clr, hold);
        model_edge(1, en, wr, rd, clr, hold & 3);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n, input int hold);
        for (int j = 0; j < n; j++) step(1, 0, 0, 0, hold);
    endtask

    initial begin
        rst_n = 0; enable = 0; wr_req = 0; rd_req = 0; clear = 0; hold8 = 8'd10;
        model_reset();
        repeat (3) @(negedge clk);
        check_all();
        rst_n = 1;

        // Write-guard sequence: trigger at cycle 5, clear at cycle 25.
        idle(4, 10);
        step(1, 1, 0, 0, 10);
        idle(19, 10);
        step(1, 0, 0, 1, 10);
        idle(3, 10);

        // Simultaneous requests.
        step(1, 1, 1, 0, 10);
        idle(20, 10);
        step(1, 0, 0, 1, 10);
        idle(2, 10);

        // Late read request during slave reset.
        step(1, 1, 0, 0, 10);
        idle(6, 10);
        step(1, 0, 1, 0, 10);
        idle(12, 10);
        step(1, 0, 0, 1, 10);
        idle(2, 10);

        // Zero hold with a stray clear during isolation.
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0);
        idle(8, 0);
        step(1, 0, 0, 1, 0);
        idle(2, 0);

        // Monitoring disabled with a held request.
        for (int j = 0; j < 6; j++) step(0, 1, 0, 0, 5);
        step(0, 0, 0, 0, 5);

        // One more sequence so the 2-bit event counter must saturate.
        step(1, 0, 1, 0, 3);
        idle(12, 3);
        chk("sat_count", int'(cnt1), 3);
        step(1, 0, 0, 1, 3);
        idle(2, 3);

        // Asynchronous reset in the middle of slave reset.
        step(1, 1, 0, 0, 10);
        idle(6, 10);
        chk("pre_reset_slv", int'(slv0), 0);
        rst_n = 0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1;

        for (int j = 0; j < 3000; j++) begin
            step($urandom_range(0, 9) != 0,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 4) == 0,
                 int'($urandom_range(0, 12)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
